// File: rtl/pwm_frame_ctrl_if.sv
// Byte stream from the SPI slave (byte mode) into pwm_frame_ctrl.
// frame_active is the synchronised, inverted chip select.
interface pwm_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_active
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_active
  );
endinterface

// File: rtl/pwm_frame_ctrl.sv
// Multi-channel PWM engine fed by byte-framed SPI writes into a shadow bank.
// Define PWM_PHASE_STAGGER_EN to spread channel phases across the period.
module pwm_frame_ctrl #(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_frame_ctrl_if.slave    rx,
  output logic [NUM_PWM-1:0] pwm_out_o,
  output logic               period_tick_o,
  output logic               commit_done_o,
  output logic               frame_err_o
);

  localparam int BYTES = (PWM_WIDTH + 7) / 8;
  localparam int WB    = BYTES * 8;

  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [6:0]           CH_LIM  = 7'(NUM_PWM);
  localparam logic [2:0]           LAST_B  = 3'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DISCARD
  } state_e;

  state_e state_q, state_d;

  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q;
  logic                 commit_q;
  logic                 pending_q, pending_d;
  logic                 err_q, err_d;
  logic                 fa_q;
  logic                 flag_q, flag_d;
  logic [6:0]           ch_q, ch_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [WB-1:0]        word_q, word_d;
  logic [NUM_PWM-1:0]   pwm_q, pwm_d;

  logic                 wr_en;
  logic [PWM_WIDTH-1:0] wr_data;
  logic                 set_req;
  logic                 commit_en;
  logic                 fa_rise;
  logic                 frame_end;

  assign cnt_d     = cnt_q + 1'b1;
  assign commit_en = pending_q && (cnt_q == CNT_MAX);
  assign fa_rise   = rx.frame_active && !fa_q;
  assign frame_end = (state_q != IDLE) && !rx.frame_active;
  assign wr_data   = word_d[PWM_WIDTH-1:0];

  // A request landing on the copy cycle stays pending for the next wrap.
  assign pending_d = (pending_q && !commit_en) || set_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fa_rise) state_d = CMD;
      end
      CMD: begin
        if (rx.rx_valid) begin
          state_d = (rx.rx_data[6:0] < CH_LIM) ? DATA : DISCARD;
        end
      end
      DATA: begin
        if (rx.rx_valid && (bcnt_q == LAST_B) &&
            (ch_q + 7'd1 == CH_LIM)) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase
    if (frame_end) state_d = IDLE;
  end

  always_comb begin
    flag_d  = flag_q;
    ch_d    = ch_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    set_req = 1'b0;

    if ((state_q == IDLE) && fa_rise) begin
      err_d  = 1'b0;
      flag_d = 1'b0;
      ch_d   = '0;
      bcnt_d = '0;
    end

    if (rx.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          err_d = err_d;
        end
        CMD: begin
          flag_d = rx.rx_data[7];
          ch_d   = rx.rx_data[6:0];
          bcnt_d = '0;
          if (rx.rx_data[6:0] >= CH_LIM) err_d = 1'b1;
        end
        DATA: begin
          word_d = (word_q << 8) | WB'(rx.rx_data);
          if (bcnt_q == LAST_B) begin
            wr_en  = 1'b1;
            ch_d   = ch_q + 7'd1;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
        DISCARD: begin
          err_d = 1'b1;
        end
        default: err_d = err_d;
      endcase
    end

    // The same-cycle byte is already folded into bcnt_d/flag_d here.
    if (frame_end) begin
      if (bcnt_d != '0) begin
        err_d = 1'b1;
      end else if (flag_d) begin
        set_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      commit_q  <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      fa_q      <= 1'b1;
      flag_q    <= 1'b0;
      ch_q      <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      pwm_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= (cnt_d == '0);
      commit_q  <= commit_en;
      pending_q <= pending_d;
      err_q     <= err_d;
      fa_q      <= rx.frame_active;
      flag_q    <= flag_d;
      ch_q      <= ch_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      pwm_q     <= pwm_d;
    end
  end

  for (genvar i = 0; i < NUM_PWM; i++) begin : g_ch
    logic [PWM_WIDTH-1:0] shadow_q;
    logic [PWM_WIDTH-1:0] active_q;
    logic [PWM_WIDTH-1:0] phase;

`ifdef PWM_PHASE_STAGGER_EN
    localparam longint unsigned STEP =
      (64'd1 << PWM_WIDTH) / 64'(NUM_PWM);
    localparam logic [PWM_WIDTH-1:0] OFS =
      PWM_WIDTH'(64'(i) * STEP);
    assign phase = cnt_q + OFS;
`else
    assign phase = cnt_q;
`endif

    assign pwm_d[i] = (phase < active_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (commit_en) active_q <= shadow_q;
        if (wr_en && (ch_q == 7'(i))) shadow_q <= wr_data;
      end
    end
  end

  assign pwm_out_o     = pwm_q;
  assign period_tick_o = tick_q;
  assign commit_done_o = commit_q;
  assign frame_err_o   = err_q;

endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Directed bench for pwm_frame_ctrl with a frame-level reference model.
// Runs at PWM_WIDTH=10 (2-byte words) so several periods fit the budget.
module tb_pwm_frame_ctrl;

  localparam int W     = 10;
  localparam int N     = 12;
  localparam int BYTES = (W + 7) / 8;
  localparam int PER   = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pwm_frame_ctrl_if bus();

  logic [N-1:0] pwm_out;
  logic         period_tick;
  logic         commit_done;
  logic         frame_err;

  pwm_frame_ctrl #(
    .PWM_WIDTH(W),
    .NUM_PWM  (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (bus),
    .pwm_out_o    (pwm_out),
    .period_tick_o(period_tick),
    .commit_done_o(commit_done),
    .frame_err_o  (frame_err)
  );

  int vecs = 0;
  int errs = 0;

  int     m_cnt;
  int     m_shadow [N];
  int     m_active [N];
  bit     m_pending, m_err, m_commit, m_tick;
  bit     m_in, m_faprev, m_flag;
  int     m_k, m_ch0, m_word;
  bit [N-1:0] m_pwm;

  int hi [N];
  int commits;
  int ticks;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic int phase(input int i);
`ifdef PWM_PHASE_STAGGER_EN
    return (m_cnt + i * (PER / N)) % PER;
`else
    return m_cnt;
`endif
  endfunction

  task automatic m_reset();
    m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_pending = 0; m_err = 0; m_commit = 0; m_tick = 0;
    m_in = 0; m_faprev = 1; m_flag = 0;
    m_k = 0; m_ch0 = 0; m_word = 0; m_pwm = '0;
  endtask

  // One clock edge of the reference model, from the inputs of that cycle.
  task automatic model_edge(input bit fa, input bit v, input logic [7:0] d);
    bit [N-1:0] p;
    bit setreq, part;
    int j, ch, dcnt;
    setreq = 0;
    for (int i = 0; i < N; i++) p[i] = (phase(i) < m_active[i]);
    m_commit = 0;
    if (m_pending && m_cnt == PER - 1) begin
      m_active = m_shadow;
      m_pending = 0;
      m_commit = 1;
    end
    if (!m_in) begin
      if (fa && !m_faprev) begin
        m_in = 1; m_k = 0; m_flag = 0; m_err = 0;
      end
    end else begin
      if (v) begin
        if (m_k == 0) begin
          m_flag = d[7];
          m_ch0 = int'(d[6:0]);
          if (m_ch0 >= N) m_err = 1;
        end else begin
          j = m_k - 1;
          ch = m_ch0 + j / BYTES;
          if (m_ch0 >= N || ch >= N) begin
            m_err = 1;
          end else begin
            m_word = (j % BYTES == 0) ? int'(d) : (m_word << 8) | int'(d);
            if (j % BYTES == BYTES - 1) m_shadow[ch] = m_word % PER;
          end
        end
        m_k++;
      end
      if (!fa) begin
        dcnt = m_k - 1;
        part = (m_k > 1) && (m_ch0 < N) && (dcnt % BYTES != 0) &&
               (m_ch0 + dcnt / BYTES < N);
        if (part) m_err = 1;
        else if (m_k > 0 && m_flag) setreq = 1;
        m_in = 0;
      end
    end
    if (setreq) m_pending = 1;
    m_faprev = fa;
    m_cnt = (m_cnt + 1) % PER;
    m_tick = (m_cnt == 0);
    m_pwm = p;
  endtask

  task automatic compare_all();
    chk("pwm_out", 64'(pwm_out), 64'(m_pwm));
    chk("period_tick", 64'(period_tick), 64'(m_tick));
    chk("commit_done", 64'(commit_done), 64'(m_commit));
    chk("frame_err", 64'(frame_err), 64'(m_err));
    for (int i = 0; i < N; i++) hi[i] += int'(pwm_out[i]);
    commits += int'(commit_done);
    ticks += int'(period_tick);
  endtask

  task automatic step(input bit fa, input bit v, input logic [7:0] d);
    bus.frame_active = fa;
    bus.rx_valid = v;
    bus.rx_data = d;
    @(posedge clk);
    model_edge(fa, v, d);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  task automatic clr_stats();
    for (int i = 0; i < N; i++) hi[i] = 0;
    commits = 0;
    ticks = 0;
  endtask

  task automatic send_frame(input logic [39:0] b, input int n);
    step(1, 0, 8'h00);
    for (int i = 0; i < n; i++) begin
      step(1, 1, b[8*(n-1-i) +: 8]);
      step(1, 0, 8'h00);
    end
    step(0, 0, 8'h00);
  endtask

  task automatic do_reset(input bit fa);
    #2;
    rst_n = 1'b0;
    bus.frame_active = fa;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 2 * PER) begin
      step(0, 0, 8'h00);
      n++;
    end
    chk("wait_cnt_bound", 64'(m_cnt), 64'(target));
  endtask

  task automatic run_until_commit();
    int n;
    n = 0;
    while (commit_done !== 1'b1 && n < 2 * PER) begin
      step(0, 0, 8'h00);
      n++;
    end
    chk("commit_seen", 64'(commit_done), 64'd1);
  endtask

  initial begin
    bus.frame_active = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    clr_stats();
    do_reset(0);

    // No frames: outputs stay low, one tick per period.
    clr_stats();
    idle(1100);
    chk("tick_count", 64'(ticks), 64'd1);

    // Commit frame: ch0 = 0x100 (256 of 1024 counts).
    send_frame(40'h80_01_00, 3);
    run_until_commit();
    chk("commit_tick_align", 64'(period_tick), 64'd1);
    idle(4);
    clr_stats();
    idle(PER);
    chk("ch0_high_256", 64'(hi[0]), 64'd256);
    chk("frame_err_clean", 64'(frame_err), 64'd0);

    // Last channel, trailing word overflows, no commit flag.
    clr_stats();
    send_frame(40'h0B_12_34_56_78, 5);
    chk("overflow_err", 64'(frame_err), 64'd1);
    idle(1100);
    chk("overflow_no_commit", 64'(commits), 64'd0);

    // Partial word at frame end.
    clr_stats();
    send_frame(40'h81_AA, 2);
    chk("partial_err", 64'(frame_err), 64'd1);
    idle(1100);
    chk("partial_no_commit", 64'(commits), 64'd0);

    // Empty frame: clears the sticky error, does nothing else.
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("empty_frame_err", 64'(frame_err), 64'd0);

    // Two commit frames merge; first one ends with byte on the falling edge.
    clr_stats();
    wait_cnt(40);
    step(1, 0, 8'h00);
    step(1, 1, 8'h82);
    step(1, 0, 8'h00);
    step(1, 1, 8'h00);
    step(0, 1, 8'h80);
    wait_cnt(PER - 9);
    send_frame(40'h83_02_00, 3);
    run_until_commit();
    chk("merged_commit_once", 64'(commits), 64'd1);
    idle(4);
    clr_stats();
    idle(PER);
    chk("ch0_hold", 64'(hi[0]), 64'd256);
    chk("ch1_partial_dropped", 64'(hi[1]), 64'd0);
    chk("ch2_high_128", 64'(hi[2]), 64'd128);
    chk("ch3_high_512", 64'(hi[3]), 64'd512);
    chk("ch11_trunc_564", 64'(hi[11]), 64'd564);
    chk("no_second_commit", 64'(commits), 64'd0);

    // Shadow write on the copy edge: copy sees the earlier value.
    wait_cnt(50);
    clr_stats();
    send_frame(40'h84_01_00, 3);
    wait_cnt(PER - 6);
    send_frame(40'h04_03_FF, 3);
    chk("race_commit_once", 64'(commits), 64'd1);
    clr_stats();
    idle(PER);
    chk("ch4_pre_write_256", 64'(hi[4]), 64'd256);
    chk("race_no_extra_commit", 64'(commits), 64'd0);

    // Reset in the middle of a data word, frame_active held high.
    step(1, 0, 8'h00);
    step(1, 1, 8'h80);
    step(1, 0, 8'h00);
    step(1, 1, 8'hFF);
    step(1, 0, 8'h00);
    do_reset(1);
    step(1, 1, 8'h81);
    step(1, 0, 8'h00);
    step(1, 1, 8'h00);
    step(0, 0, 8'h00);
    idle(3);
    send_frame(40'h80_FF_FF, 3);
    run_until_commit();
    idle(4);
    clr_stats();
    idle(PER);
    chk("ch0_full_1023", 64'(hi[0]), 64'd1023);
    chk("ch11_after_reset", 64'(hi[11]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
